// File: rtl/o3.sv
// o3: samples the nibble {a,b,c,d} every clock, flags primes on y and
// flags a run of four consecutive counting values (mod 16) on z.
module o3 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y,
    output logic z,
    input  logic clk,
    input  logic rst
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        DET  = 2'd3
    } run_state_t;

    // Prime lookup over the 4-bit sample range.
    function automatic logic is_prime(input logic [3:0] val);
        logic res;
        case (val)
            4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: res = 1'b1;
            default:                              res = 1'b0;
        endcase
        return res;
    endfunction

    logic [3:0] v_s;
    logic       inc_s;

    run_state_t state_q, state_d;
    logic [3:0] prev_q, prev_d;
    logic       pvalid_q, pvalid_d;
    logic       y_q, y_d;
    logic       z_q, z_d;

    assign v_s   = {a, b, c, d};
    // Natural 4-bit wrap makes 15 -> 0 an increment.
    assign inc_s = pvalid_q && (v_s == (prev_q + 4'd1));

    // Next-state and next-output logic.
    always_comb begin
        state_d  = IDLE;
        prev_d   = v_s;
        pvalid_d = 1'b1;
        y_d      = is_prime(v_s);
        if (inc_s) begin
            case (state_q)
                IDLE:    state_d = S1;
                S1:      state_d = S2;
                S2:      state_d = DET;
                DET:     state_d = DET;
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = IDLE;
        end
        z_d = (state_d == DET);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            prev_q   <= 4'd0;
            pvalid_q <= 1'b0;
            y_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            pvalid_q <= pvalid_d;
            y_q      <= y_d;
            z_q      <= z_d;
        end
    end

    assign y = y_q;
    assign z = z_q;

endmodule

// File: tb/tb_o3.sv
// Directed self-checking bench for o3: prime flag and counting-run detect.
`timescale 1ns/1ps
module tb_o3;

    logic a, b, c, d, y, z, clk, rst;
    int checks   = 0;
    int failures = 0;

    o3 dut (
        .a(a), .b(b), .c(c), .d(d),
        .y(y), .z(z),
        .clk(clk), .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Drive V at the falling edge, then look 1 ns after the rising edge.
    task automatic step(input logic [3:0] v, input logic ey, input logic ez, input string tag);
        @(negedge clk);
        {a, b, c, d} = v;
        @(posedge clk);
        #1;
        check({tag, "_y"}, y, ey);
        check({tag, "_z"}, z, ez);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_rst_y"}, y, 1'b0);
        check({tag, "_rst_z"}, z, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [15:0] prime_tab;
    logic [15:0] zrun_tab;

    initial begin
        rst = 1'b1;
        {a, b, c, d} = 4'd0;
        #2;
        check("por_y", y, 1'b0);
        check("por_z", z, 1'b0);

        // Count 0..15 after reset
        do_reset("s1");
        prime_tab = 16'b0010_1000_1010_1100;
        zrun_tab  = 16'b1111_1111_1111_1000;
        for (int i = 0; i < 16; i++)
            step(i[3:0], prime_tab[i], zrun_tab[i], $sformatf("s1_v%0d", i));

        // Wrap 15 -> 0 counts
        do_reset("s2");
        step(4'd14, 1'b0, 1'b0, "s2_v14");
        step(4'd15, 1'b0, 1'b0, "s2_v15");
        step(4'd0,  1'b0, 1'b0, "s2_v0");
        step(4'd1,  1'b0, 1'b1, "s2_v1");

        // Repeated value restarts the run
        do_reset("s3");
        step(4'd4, 1'b0, 1'b0, "s3_v4");
        step(4'd5, 1'b1, 1'b0, "s3_v5");
        step(4'd6, 1'b0, 1'b0, "s3_v6");
        step(4'd6, 1'b0, 1'b0, "s3_v6r");
        step(4'd7, 1'b1, 1'b0, "s3_v7");
        step(4'd8, 1'b0, 1'b0, "s3_v8");
        step(4'd9, 1'b0, 1'b1, "s3_v9");

        // Async reset mid-run discards history
        do_reset("s4");
        step(4'd0, 1'b0, 1'b0, "s4_v0");
        step(4'd1, 1'b0, 1'b0, "s4_v1");
        step(4'd2, 1'b1, 1'b0, "s4_v2");
        step(4'd3, 1'b1, 1'b1, "s4_v3");
        step(4'd4, 1'b0, 1'b1, "s4_v4");
        rst = 1'b1;
        #1;
        check("s4_async_y", y, 1'b0);
        check("s4_async_z", z, 1'b0);
        #2;
        rst = 1'b0;
        step(4'd5, 1'b1, 1'b0, "s4_v5");
        step(4'd6, 1'b0, 1'b0, "s4_v6");
        step(4'd7, 1'b1, 1'b0, "s4_v7");
        step(4'd8, 1'b0, 1'b1, "s4_v8");

        // Break of a detected run
        do_reset("s5");
        step(4'd0, 1'b0, 1'b0, "s5_v0");
        step(4'd1, 1'b0, 1'b0, "s5_v1");
        step(4'd2, 1'b1, 1'b0, "s5_v2");
        step(4'd3, 1'b1, 1'b1, "s5_v3");
        step(4'd9, 1'b0, 1'b0, "s5_v9");

        // Constant 13, plus a glitch between edges that must not show
        do_reset("s6");
        for (int i = 0; i < 5; i++)
            step(4'd13, 1'b1, 1'b0, $sformatf("s6_c%0d", i));
        {a, b, c, d} = 4'd4;
        #2;
        {a, b, c, d} = 4'd13;
        #1;
        check("s6_glitch_y", y, 1'b1);
        check("s6_glitch_z", z, 1'b0);
        step(4'd13, 1'b1, 1'b0, "s6_c5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
